// File: rtl/cop0_pkg.sv
// +--------------------------------------------------------------------------+
// | cop0_pkg : command encodings, register map and field helpers for CP0     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package cop0_pkg;

  localparam logic [2:0] COP_OP_NOP = 3'd0;
  localparam logic [2:0] COP_OP_SYS = 3'd1;
  localparam logic [2:0] COP_OP_BRK = 3'd2;
  localparam logic [2:0] COP_OP_RET = 3'd3;
  localparam logic [2:0] COP_OP_MV  = 3'd4;
  localparam logic [2:0] COP_OP_EN  = 3'd5;
  localparam logic [2:0] COP_OP_DIS = 3'd6;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;

  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] v;
    v                  = '0;
    v[ST_IE]           = s.ie;
    v[ST_EXL]          = s.exl;
    v[ST_IM_LO +: 8]   = s.im;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic [7:0] ip, input logic [4:0] exc);
    logic [31:0] v;
    v                  = '0;
    v[CA_EXC_LO +: 5]  = exc;
    v[CA_IP_LO +: 8]   = ip;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cop0_timer.sv
// +--------------------------------------------------------------------------+
// | cop0_timer : free-running Count, Compare and the timer-pending flag      |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module cop0_timer
  import cop0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  // Match is taken against the post-update values so a write that lands on
  // the current compare value raises the flag on the same edge.
  always_comb begin
    count_d   = wr_count_i ? wdata_i : count_q + 32'd1;
    compare_d = wr_compare_i ? wdata_i : compare_q;
    pending_d = (pending_q & ~wr_compare_i) | (count_d == compare_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= COMPARE_RESET;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

`default_nettype wire

// File: rtl/cop0.sv
// +--------------------------------------------------------------------------+
// | cop0 : system-control coprocessor (Status/Cause/EPC, exceptions, IRQs)   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module cop0
  import cop0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  cop0_op,
  input  logic        cop0_rd,
  input  logic        cop0_wr,
  input  logic [4:0]  reg_idx,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        exc_take,
  output logic [31:0] exc_target,
  output logic        int_req
);

  status_t     status_q, status_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [31:0] epc_q, epc_d;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer_pending;

  logic [7:0]  w_ip;
  logic [31:0] w_status_word;
  logic [31:0] w_cause_word;
  logic [31:0] w_read_mux;
  logic        w_take_int;
  logic        w_cmd_ok;
  logic        w_is_exc;
  logic        w_is_ret;
  logic        w_is_mv;
  logic        w_is_ei;
  logic        w_is_di;
  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;

  // The timer line shares IP[7] with the top hardware interrupt input.
  assign w_ip          = {ip_hw_q[5] | w_timer_pending, ip_hw_q[4:0], ip_sw_q};
  assign w_status_word = pack_status(status_q);
  assign w_cause_word  = pack_cause(w_ip, exccode_q);

  assign int_req    = status_q.ie & ~status_q.exl & (|(w_ip & status_q.im));
  assign w_take_int = en & int_req;
  assign w_cmd_ok   = en & ~int_req;

  assign w_is_exc = w_cmd_ok & ((cop0_op == COP_OP_SYS) | (cop0_op == COP_OP_BRK));
  assign w_is_ret = w_cmd_ok & (cop0_op == COP_OP_RET);
  assign w_is_mv  = w_cmd_ok & (cop0_op == COP_OP_MV);
  assign w_is_ei  = w_cmd_ok & (cop0_op == COP_OP_EN);
  assign w_is_di  = w_cmd_ok & (cop0_op == COP_OP_DIS);
  assign w_mtc0   = w_is_mv & cop0_rd;

  assign w_wr_count   = w_mtc0 & (reg_idx == CP0_COUNT);
  assign w_wr_compare = w_mtc0 & (reg_idx == CP0_COMPARE);

  assign exc_take   = w_take_int | w_is_exc | w_is_ret;
  assign exc_target = w_is_ret ? epc_q : EXC_VECTOR;

  always_comb begin
    w_read_mux = '0;
    case (reg_idx)
      CP0_COUNT:   w_read_mux = w_count;
      CP0_COMPARE: w_read_mux = w_compare;
      CP0_STATUS:  w_read_mux = w_status_word;
      CP0_CAUSE:   w_read_mux = w_cause_word;
      CP0_EPC:     w_read_mux = epc_q;
      default:     w_read_mux = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (w_is_mv && cop0_wr) begin
      rdata = w_read_mux;
    end else if (w_is_ei || w_is_di) begin
      rdata = w_status_word;
    end
  end

  always_comb begin
    status_d  = status_q;
    exccode_d = exccode_q;
    ip_sw_d   = ip_sw_q;
    epc_d     = epc_q;
    if (w_take_int) begin
      epc_d        = pc;
      exccode_d    = EXC_INT;
      status_d.exl = 1'b1;
    end else if (w_is_exc) begin
      // A nested trap keeps the original return address.
      if (!status_q.exl) begin
        epc_d = pc;
      end
      exccode_d    = (cop0_op == COP_OP_SYS) ? EXC_SYS : EXC_BP;
      status_d.exl = 1'b1;
    end else if (w_is_ret) begin
      status_d.exl = 1'b0;
    end else if (w_mtc0) begin
      case (reg_idx)
        CP0_STATUS: begin
          status_d.ie  = wdata[ST_IE];
          status_d.exl = wdata[ST_EXL];
          status_d.im  = wdata[ST_IM_LO +: 8];
        end
        CP0_CAUSE: ip_sw_d = wdata[CA_IP_LO +: 2];
        CP0_EPC:   epc_d   = wdata;
        default:   ;
      endcase
    end else if (w_is_ei) begin
      status_d.ie = 1'b1;
    end else if (w_is_di) begin
      status_d.ie = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= '0;
      exccode_q <= '0;
      ip_sw_q   <= '0;
      ip_hw_q   <= '0;
      epc_q     <= '0;
    end else begin
      status_q  <= status_d;
      exccode_q <= exccode_d;
      ip_sw_q   <= ip_sw_d;
      ip_hw_q   <= hw_int;
      epc_q     <= epc_d;
    end
  end

  cop0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .wr_count_i   (w_wr_count),
    .wr_compare_i (w_wr_compare),
    .wdata_i      (wdata),
    .count_o      (w_count),
    .compare_o    (w_compare),
    .pending_o    (w_timer_pending)
  );

endmodule

`default_nettype wire

// File: tb/tb_cop0.sv
// +--------------------------------------------------------------------------+
// | tb_cop0 : directed plus random stimulus against an architectural model   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cop0;
  import cop0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  cop0_op;
  logic        cop0_rd;
  logic        cop0_wr;
  logic [4:0]  reg_idx;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic        exc_take;
  logic [31:0] exc_target;
  logic        int_req;

  int checks   = 0;
  int failures = 0;

  // Architectural model: Status/Cause kept as their 32-bit register images.
  logic [31:0] m_status;
  logic [31:0] m_cause;
  logic [31:0] m_epc;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_pend;
  logic [5:0]  m_hw;

  always #5 clk = ~clk;

  cop0 dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cop0_op    (cop0_op),
    .cop0_rd    (cop0_rd),
    .cop0_wr    (cop0_wr),
    .reg_idx    (reg_idx),
    .wdata      (wdata),
    .pc         (pc),
    .hw_int     (hw_int),
    .rdata      (rdata),
    .exc_take   (exc_take),
    .exc_target (exc_target),
    .int_req    (int_req)
  );

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_pend, m_hw[4:0], m_cause[9:8]};
  endfunction

  function automatic logic m_intr();
    return m_status[0] & ~m_status[1] & (|(m_ip() & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    case (idx)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return (m_cause & 32'h0000_007C) | ({24'b0, m_ip()} << 8);
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status  = 32'h0;
    m_cause   = 32'h0;
    m_epc     = 32'h0;
    m_count   = 32'h0;
    m_compare = 32'hFFFF_FFFF;
    m_pend    = 1'b0;
    m_hw      = 6'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cop0_op = COP_OP_NOP; cop0_rd = 1'b0; cop0_wr = 1'b0;
    reg_idx = 5'd0; wdata = 32'h0; pc = 32'h0; hw_int = 6'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic e, input logic [2:0] op, input logic rd, input logic wr,
                      input logic [4:0] idx, input logic [31:0] wd, input logic [31:0] p,
                      input logic [5:0] hw, input string tag);
    logic        intr;
    logic        e_take;
    logic [31:0] e_tgt;
    logic [31:0] e_rd;
    logic [31:0] ncount;
    logic [31:0] ncompare;
    logic        npend;
    en = e; cop0_op = op; cop0_rd = rd; cop0_wr = wr; reg_idx = idx; wdata = wd; pc = p; hw_int = hw;
    #3;
    intr   = m_intr();
    e_take = e & (intr | op == COP_OP_SYS | op == COP_OP_BRK | op == COP_OP_RET);
    e_tgt  = (e && !intr && op == COP_OP_RET) ? m_epc : 32'h0000_0080;
    e_rd   = 32'h0;
    if (e && !intr) begin
      if (op == COP_OP_MV && wr) e_rd = m_read(idx);
      else if (op == COP_OP_EN || op == COP_OP_DIS) e_rd = m_status;
    end
    checks++;
    assert (int_req === intr) else begin
      failures++;
      $error("FAIL %s int_req got=%b exp=%b", tag, int_req, intr);
    end
    checks++;
    assert (exc_take === e_take) else begin
      failures++;
      $error("FAIL %s exc_take got=%b exp=%b", tag, exc_take, e_take);
    end
    checks++;
    assert (rdata === e_rd) else begin
      failures++;
      $error("FAIL %s rdata got=%h exp=%h", tag, rdata, e_rd);
    end
    if (e_take) begin
      checks++;
      assert (exc_target === e_tgt) else begin
        failures++;
        $error("FAIL %s exc_target got=%h exp=%h", tag, exc_target, e_tgt);
      end
    end
    @(posedge clk);
    ncount   = m_count + 32'd1;
    ncompare = m_compare;
    npend    = m_pend;
    if (e) begin
      if (intr) begin
        m_epc       = p;
        m_cause[6:2] = 5'd0;
        m_status[1] = 1'b1;
      end else begin
        case (op)
          COP_OP_SYS, COP_OP_BRK: begin
            if (!m_status[1]) m_epc = p;
            m_cause[6:2] = (op == COP_OP_SYS) ? 5'd8 : 5'd9;
            m_status[1]  = 1'b1;
          end
          COP_OP_RET: m_status[1] = 1'b0;
          COP_OP_MV: if (rd) begin
            case (idx)
              5'd9:  ncount = wd;
              5'd11: begin ncompare = wd; npend = 1'b0; end
              5'd12: m_status = wd & 32'h0000_FF03;
              5'd13: m_cause  = (m_cause & ~32'h0000_0300) | (wd & 32'h0000_0300);
              5'd14: m_epc    = wd;
              default: ;
            endcase
          end
          COP_OP_EN:  m_status[0] = 1'b1;
          COP_OP_DIS: m_status[0] = 1'b0;
          default: ;
        endcase
      end
    end
    m_pend    = npend | (ncount == ncompare);
    m_count   = ncount;
    m_compare = ncompare;
    m_hw      = hw;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ridx;
    logic [31:0] rwd;
    logic [5:0]  rhw;
    logic [2:0]  rop;
    int          sel;

    do_reset();
    step(1, COP_OP_MV, 0, 1, CP0_STATUS,  0, 32'h100, 0, "rst_status");
    step(1, COP_OP_MV, 0, 1, CP0_COMPARE, 0, 32'h104, 0, "rst_compare");
    step(1, COP_OP_MV, 0, 1, CP0_CAUSE,   0, 32'h108, 0, "rst_cause");

    step(1, COP_OP_SYS, 0, 0, 0, 0, 32'h0000_1000, 0, "sys");
    step(1, COP_OP_MV, 0, 1, CP0_EPC,    0, 32'h1004, 0, "sys_epc");
    step(1, COP_OP_MV, 0, 1, CP0_CAUSE,  0, 32'h1008, 0, "sys_cause");
    step(1, COP_OP_MV, 0, 1, CP0_STATUS, 0, 32'h100C, 0, "sys_status");
    step(1, COP_OP_RET, 0, 0, 0, 0, 32'h1010, 0, "eret");
    step(1, COP_OP_MV, 0, 1, CP0_STATUS, 0, 32'h1000, 0, "eret_status");

    step(1, COP_OP_MV, 1, 0, CP0_STATUS, 32'h0000_0401, 32'h1F00, 6'h01, "irq_setup");
    step(0, COP_OP_NOP, 0, 0, 0, 0, 32'h1F04, 6'h01, "irq_pend");
    step(1, COP_OP_SYS, 0, 0, 0, 0, 32'h0000_2000, 6'h01, "irq_take");
    step(1, COP_OP_MV, 0, 1, CP0_EPC,   0, 32'h80, 6'h01, "irq_epc");
    step(1, COP_OP_MV, 0, 1, CP0_CAUSE, 0, 32'h84, 6'h00, "irq_cause");
    step(1, COP_OP_RET, 0, 0, 0, 0, 32'h88, 6'h00, "irq_ret");

    step(1, COP_OP_MV, 1, 0, CP0_COMPARE, 32'd5, 32'h300, 0, "tmr_cmp");
    step(1, COP_OP_MV, 1, 0, CP0_COUNT,   32'd0, 32'h304, 0, "tmr_cnt");
    step(1, COP_OP_MV, 1, 0, CP0_STATUS,  32'h0000_8001, 32'h308, 0, "tmr_status");
    for (int i = 0; i < 6; i++) step(0, COP_OP_NOP, 0, 0, 0, 0, 32'h30C, 0, "tmr_wait");
    step(1, COP_OP_NOP, 0, 0, 0, 0, 32'h320, 0, "tmr_take");
    step(1, COP_OP_MV, 1, 0, CP0_COMPARE, 32'h0000_1000, 32'h80, 0, "tmr_clr");
    step(1, COP_OP_MV, 1, 0, CP0_STATUS,  32'h0000_8001, 32'h84, 0, "tmr_reen");
    step(0, COP_OP_NOP, 0, 0, 0, 0, 32'h88, 0, "tmr_idle");

    step(1, COP_OP_MV, 1, 0, CP0_STATUS, 32'h0, 32'h400, 0, "ei_clear");
    step(1, COP_OP_EN,  0, 0, 0, 0, 32'h404, 0, "ei");
    step(1, COP_OP_MV, 0, 1, CP0_STATUS, 0, 32'h408, 0, "ei_status");
    step(1, COP_OP_DIS, 0, 0, 0, 0, 32'h40C, 0, "di");
    step(1, COP_OP_MV, 0, 1, CP0_STATUS, 0, 32'h410, 0, "di_status");

    step(1, COP_OP_MV, 1, 0, CP0_EPC,    32'h0000_3000, 32'h500, 0, "brk_epc");
    step(1, COP_OP_MV, 1, 0, CP0_STATUS, 32'h0000_0002, 32'h504, 0, "brk_exl");
    step(1, COP_OP_BRK, 0, 0, 0, 0, 32'h0000_5555, 0, "brk_nested");
    step(1, COP_OP_MV, 0, 1, CP0_EPC,   0, 32'h508, 0, "brk_epc_kept");
    step(1, COP_OP_MV, 0, 1, CP0_CAUSE, 0, 32'h50C, 0, "brk_cause");

    step(1, COP_OP_MV, 1, 0, CP0_CAUSE, 32'hFFFF_FFFF, 32'h600, 0, "sw_ip");
    step(1, COP_OP_MV, 0, 1, CP0_CAUSE, 0, 32'h604, 0, "sw_ip_read");
    step(1, COP_OP_MV, 1, 0, 5'd20, 32'hDEAD_BEEF, 32'h608, 0, "bad_idx_wr");
    step(1, COP_OP_MV, 0, 1, 5'd20, 0, 32'h60C, 0, "bad_idx_rd");
    step(0, COP_OP_MV, 1, 0, CP0_EPC, 32'h1234_5678, 32'h610, 0, "en_low_wr");
    step(1, COP_OP_MV, 0, 1, CP0_EPC, 0, 32'h614, 0, "en_low_rd");

    step(1, COP_OP_SYS, 0, 0, 0, 0, 32'h700, 0, "pre_rst_sys");
    do_reset();
    step(1, COP_OP_MV, 0, 1, CP0_STATUS, 0, 32'h704, 0, "mid_rst_status");
    step(1, COP_OP_MV, 0, 1, CP0_EPC,    0, 32'h708, 0, "mid_rst_epc");

    rhw = 6'h0;
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: ridx = CP0_COUNT;
        1: ridx = CP0_COMPARE;
        2, 3: ridx = CP0_STATUS;
        4: ridx = CP0_CAUSE;
        5: ridx = CP0_EPC;
        default: ridx = 5'($urandom_range(0, 31));
      endcase
      rwd = $urandom;
      if (ridx == CP0_COMPARE) rwd = m_count + 32'($urandom_range(2, 8));
      if ($urandom_range(0, 7) == 0) rhw = 6'($urandom_range(0, 63));
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) rop = COP_OP_MV;
      step(1'($urandom_range(0, 3) != 0), rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ridx, rwd, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, rhw, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
